// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants, forwarding-select enum and match helper
package pipe_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] ALU_ADD    = 5'b00000;
  localparam logic [4:0] ALU_SUB    = 5'b00001;
  localparam logic [4:0] ALU_LUI    = 5'b00011;
  localparam logic [4:0] ALU_SLL    = 5'b01000;
  localparam logic [4:0] ALU_SRL    = 5'b01001;
  localparam logic [4:0] ALU_SRA    = 5'b01010;
  localparam logic [4:0] ALU_MUL    = 5'b10000;
  localparam logic [4:0] ALU_MULH   = 5'b10001;
  localparam logic [4:0] ALU_MULHSU = 5'b10010;
  localparam logic [4:0] ALU_MULHU  = 5'b10011;
  localparam logic [4:0] ALU_DIV    = 5'b10100;
  localparam logic [4:0] ALU_DIVU   = 5'b10101;
  localparam logic [4:0] ALU_REM    = 5'b10110;
  localparam logic [4:0] ALU_REMU   = 5'b10111;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;

  // x0 is hardwired zero, so a write to it must never be forwarded
  function automatic logic fwd_hit(input logic [4:0] rd, input logic we, input logic [4:0] rs);
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID/EX stage bus: decoded fields in, forwarding sources in, ALU operands out
interface id_ex_stage_if
  import pipe_pkg::*;
#(
  parameter int XLEN = 32
);
  logic            flush;
  logic            hold;
  logic            id_valid;
  logic [4:0]      id_alu_sel;
  logic [4:0]      id_shamt;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic            id_use_imm;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic            id_reg_write;
  logic            id_mem_read;
  logic            id_mem_write;
  logic [4:0]      exm_rd;
  logic            exm_reg_write;
  logic [XLEN-1:0] exm_result;
  logic [4:0]      mwb_rd;
  logic            mwb_reg_write;
  logic [XLEN-1:0] mwb_result;

  logic            stall;
  logic            ex_valid;
  logic [4:0]      alu_sel;
  logic [4:0]      alu_shamt;
  logic [XLEN-1:0] alu_r1;
  logic [XLEN-1:0] alu_r2;
  logic [XLEN-1:0] ex_store_data;
  logic [4:0]      ex_rd;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;
  fwd_sel_t        fwd_rs1;
  fwd_sel_t        fwd_rs2;

  modport master (
    output flush, hold, id_valid, id_alu_sel, id_shamt, id_rs1_data, id_rs2_data,
           id_imm, id_use_imm, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read,
           id_mem_write, exm_rd, exm_reg_write, exm_result, mwb_rd, mwb_reg_write,
           mwb_result,
    input  stall, ex_valid, alu_sel, alu_shamt, alu_r1, alu_r2, ex_store_data,
           ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, fwd_rs1, fwd_rs2
  );

  modport slave (
    input  flush, hold, id_valid, id_alu_sel, id_shamt, id_rs1_data, id_rs2_data,
           id_imm, id_use_imm, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read,
           id_mem_write, exm_rd, exm_reg_write, exm_result, mwb_rd, mwb_reg_write,
           mwb_result,
    output stall, ex_valid, alu_sel, alu_shamt, alu_r1, alu_r2, ex_store_data,
           ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, fwd_rs1, fwd_rs2
  );

endinterface

// File: rtl/forward_mux.sv
// rtl/forward_mux.sv - per-operand bypass select: EX/MEM over MEM/WB over registered data
module forward_mux
  import pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      rs,
  input  logic [XLEN-1:0] reg_data,
  input  logic [4:0]      exm_rd,
  input  logic            exm_reg_write,
  input  logic [XLEN-1:0] exm_result,
  input  logic [4:0]      mwb_rd,
  input  logic            mwb_reg_write,
  input  logic [XLEN-1:0] mwb_result,
  output logic [XLEN-1:0] data,
  output fwd_sel_t        sel
);

  always_comb begin
    sel  = FWD_NONE;
    data = reg_data;
    // EX/MEM holds the younger write, so it wins when both match
    if (fwd_hit(exm_rd, exm_reg_write, rs)) begin
      sel  = FWD_EXMEM;
      data = exm_result;
    end else if (fwd_hit(mwb_rd, mwb_reg_write, rs)) begin
      sel  = FWD_MEMWB;
      data = mwb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall and operand forwarding
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic         clk,
  input logic         rst,
  id_ex_stage_if.slave bus
);

  logic            ex_valid_q;
  logic [4:0]      alu_sel_q;
  logic [4:0]      shamt_q;
  logic [XLEN-1:0] rs1_data_q;
  logic [XLEN-1:0] rs2_data_q;
  logic [XLEN-1:0] imm_q;
  logic            use_imm_q;
  logic [4:0]      rs1_q;
  logic [4:0]      rs2_q;
  logic [4:0]      rd_q;
  logic            reg_write_q;
  logic            mem_read_q;
  logic            mem_write_q;

  logic            load_use;
  logic            stall;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;

  // rs2 is compared even for I-type; a spurious bubble is cheaper than decoding format here
  assign load_use = bus.id_valid && ex_valid_q && mem_read_q && (rd_q != 5'd0) &&
                    ((bus.id_rs1 == rd_q) || (bus.id_rs2 == rd_q));
  assign stall    = load_use && !bus.flush && !bus.hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      alu_sel_q   <= ALU_ADD;
      shamt_q     <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      use_imm_q   <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else if (bus.flush || (stall && !bus.hold)) begin
      ex_valid_q  <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else if (!bus.hold) begin
      ex_valid_q  <= bus.id_valid;
      alu_sel_q   <= bus.id_alu_sel;
      shamt_q     <= bus.id_shamt;
      rs1_data_q  <= bus.id_rs1_data;
      rs2_data_q  <= bus.id_rs2_data;
      imm_q       <= bus.id_imm;
      use_imm_q   <= bus.id_use_imm;
      rs1_q       <= bus.id_rs1;
      rs2_q       <= bus.id_rs2;
      rd_q        <= bus.id_rd;
      reg_write_q <= bus.id_valid && bus.id_reg_write;
      mem_read_q  <= bus.id_valid && bus.id_mem_read;
      mem_write_q <= bus.id_valid && bus.id_mem_write;
    end
  end

  forward_mux #(.XLEN(XLEN)) u_fwd_rs1 (
    .rs            (rs1_q),
    .reg_data      (rs1_data_q),
    .exm_rd        (bus.exm_rd),
    .exm_reg_write (bus.exm_reg_write),
    .exm_result    (bus.exm_result),
    .mwb_rd        (bus.mwb_rd),
    .mwb_reg_write (bus.mwb_reg_write),
    .mwb_result    (bus.mwb_result),
    .data          (rs1_fwd),
    .sel           (bus.fwd_rs1)
  );

  forward_mux #(.XLEN(XLEN)) u_fwd_rs2 (
    .rs            (rs2_q),
    .reg_data      (rs2_data_q),
    .exm_rd        (bus.exm_rd),
    .exm_reg_write (bus.exm_reg_write),
    .exm_result    (bus.exm_result),
    .mwb_rd        (bus.mwb_rd),
    .mwb_reg_write (bus.mwb_reg_write),
    .mwb_result    (bus.mwb_result),
    .data          (rs2_fwd),
    .sel           (bus.fwd_rs2)
  );

  assign bus.stall         = stall;
  assign bus.ex_valid      = ex_valid_q;
  assign bus.alu_sel       = alu_sel_q;
  // register shifts take their amount from the forwarded rs2 low bits
  assign bus.alu_shamt     = use_imm_q ? shamt_q : rs2_fwd[4:0];
  assign bus.alu_r1        = rs1_fwd;
  assign bus.alu_r2        = use_imm_q ? imm_q : rs2_fwd;
  assign bus.ex_store_data = rs2_fwd;
  assign bus.ex_rd         = rd_q;
  assign bus.ex_reg_write  = reg_write_q;
  assign bus.ex_mem_read   = mem_read_q;
  assign bus.ex_mem_write  = mem_write_q;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the pipelined RV32IM core; sits directly upstream of the ALU and drives its `sel`, `shamt`, `R1` and `R2` inputs. It registers decoded instruction fields and applies EX/MEM and MEM/WB operand forwarding to the registered operands. It detects load-use hazards, stalling ID and inserting a bubble, and honours branch flush and downstream hold.

## Interface
- `XLEN`, 32: datapath width; the ALU is 32-bit, so only 32 is supported.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: branch/jump redirect; kills the instruction entering EX.
- `hold` in 1: downstream freeze; asserted only while EX/MEM and MEM/WB are also frozen.
- `id_valid` in 1: ID holds a real instruction.
- `id_alu_sel` in 5, `id_shamt` in 5: ALU operation code and immediate shift amount.
- `id_rs1_data` in 32, `id_rs2_data` in 32: register-file read data.
- `id_imm` in 32, `id_use_imm` in 1: immediate operand and its select.
- `id_rs1` in 5, `id_rs2` in 5, `id_rd` in 5: register indices.
- `id_reg_write` in 1, `id_mem_read` in 1, `id_mem_write` in 1: control bits.
- `exm_rd` in 5, `exm_reg_write` in 1, `exm_result` in 32: EX/MEM forwarding source.
- `mwb_rd` in 5, `mwb_reg_write` in 1, `mwb_result` in 32: MEM/WB forwarding source.
- `stall` out 1: hold PC and IF/ID this cycle.
- `ex_valid` out 1: EX holds a real instruction.
- `alu_sel` out 5, `alu_shamt` out 5, `alu_r1` out 32, `alu_r2` out 32: ALU inputs.
- `ex_store_data` out 32: forwarded rs2, for stores.
- `ex_rd` out 5, `ex_reg_write` out 1, `ex_mem_read` out 1, `ex_mem_write` out 1: control bits to EX/MEM.

## Operation
- Register update priority: `rst` > `flush` > `hold` > load-use bubble > capture.
  - **Flush:** clear `ex_valid`, `ex_reg_write`, `ex_mem_read` and `ex_mem_write`. Datapath fields are don't-care.
  - **Hold:** every register keeps its value.
  - **Bubble (`stall`=1):** same clearing as flush. ID is not consumed.
  - **Capture:** load all `id_*` fields. `ex_valid` takes `id_valid`. If `id_valid`=0, control bits are loaded as 0.
- Load-use detection is combinational: `stall` = `id_valid` & `ex_valid` & `ex_mem_read` & (`ex_rd`≠0) & (`id_rs1`==`ex_rd` | `id_rs2`==`ex_rd`).
  - Detection is conservative: rs2 is compared even for I-type instructions.
  - `stall` is forced to 0 while `flush` or `hold` is high.
- Forwarding is combinational, per source operand (rs1, rs2), applied to the registered rs data:
  - EX/MEM if `exm_reg_write` & `exm_rd`≠0 & `exm_rd`==rs.
  - Otherwise MEM/WB under the same rule.
  - Otherwise the registered data.
  - EX/MEM has priority when both sources match.
  - x0 never forwards.
- ALU operand outputs:
  - `alu_r1` = forwarded rs1.
  - `alu_r2` = `use_imm` ? `imm` : forwarded rs2.
  - `ex_store_data` = forwarded rs2, regardless of `use_imm`.
  - `alu_shamt` = `use_imm` ? registered `shamt` : forwarded rs2[4:0]. This covers SLL/SRL/SRA, since the ALU shifts by `shamt`.
- `alu_sel` passes through from its register; LUI is carried as `alu_r2`=`imm`.
- Forwarding is re-evaluated every cycle, including during hold.

## Timing
- Reset values: all registered outputs 0, `ex_valid`=0, `alu_sel`=0 (ADD). After reset `stall`=0 and all `alu_*`=0, given zeroed forwarding inputs.
- Latency: an ID instruction appears at the EX outputs one cycle after capture.
- Forwarded operand paths have zero-cycle latency from the `exm_*` and `mwb_*` inputs.
- Load-use costs exactly one bubble. The next cycle the load is in EX/MEM; the bubble clears `ex_mem_read`, so `stall` drops and the value forwards from MEM/WB one cycle later.
- `flush` together with `stall`: flush wins, `stall`=0, and ID is overwritten by upstream redirect.
- `rst` deasserted mid-stream: first capture happens at the first rising edge after deassertion.
- Operand width is 32 bits throughout; `shamt` takes bits [4:0] only.

## Structure
- Shared package `pipe_pkg` holds:
  - ALU `sel` constants (ADD=5'b00000, SUB=5'b00001, LUI=5'b00011, SLL/SRL/SRA=5'b01000/01001/01010, MUL…REMU).
  - A forwarding-select enum: `FWD_NONE`, `FWD_EXMEM`, `FWD_MEMWB`.
- Sub-module `forward_mux`: inputs rs index, registered data and both forwarding sources; outputs the forwarded value and the select. Instantiated twice, for rs1 and rs2.

## Test plan
- Reset mid-stream: assert `rst` with `ex_valid`=1, `ex_reg_write`=1 → all outputs 0 immediately, without waiting for a clock edge.
- EX/MEM forward: EX holds rs1=5 with data 0x11; `exm_rd`=5, `exm_reg_write`=1, `exm_result`=0x99 → `alu_r1`=0x99. Same setup with `exm_rd`=0 → `alu_r1`=0x11.
- Double match: `exm_rd`=`mwb_rd`=7, results 0xA / 0xB, EX rs2=7, `use_imm`=0 → `alu_r2`=0xA, `alu_shamt`=5'h0A.
- Load-use: EX holds LW x3; ID holds ADD rs1=3, `id_valid`=1 → `stall`=1 for one cycle. Next cycle `ex_valid`=0 and `stall`=0.
- Flush during stall: same setup plus `flush`=1 → `stall`=0; next cycle `ex_valid`=0 and `ex_reg_write`=0.
- Hold: `hold`=1 for 3 cycles with ID toggling → EX registers unchanged; `alu_r1` tracks a changing `exm_result` when `exm_rd` matches.
